// File: rtl/operand_fetch.sv
// operand_fetch: register file, busy scoreboard and registered
// operand issue slot feeding the ALU.
package of_pkg;
  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic [4:0] op;
    reg_addr_t  rd;
  } iss_ctl_t;
endpackage

module operand_fetch
  import of_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [4:0]    in_ra,
  input  logic [4:0]    in_rb,
  input  logic [4:0]    in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_op,
  output logic [4:0]    out_rd,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_n;

  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  iss_ctl_t      ctl_q;
  logic          vld_q;

  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic          wb_hit;
  logic          blk_a;
  logic          blk_b;
  logic          blk_d;
  logic          hazard;
  logic          accept;

  assign wb_hit = wb_en && (wb_addr != '0);

  // Write-back data is bypassed straight into the issuing operands.
  always_comb begin
    src_a = '0;
    if (in_ra == '0)
      src_a = '0;
    else if (wb_en && (wb_addr == in_ra))
      src_a = wb_data;
    else
      src_a = regs[in_ra];
  end

  always_comb begin
    src_b = '0;
    if (in_rb == '0)
      src_b = '0;
    else if (wb_en && (wb_addr == in_rb))
      src_b = wb_data;
    else
      src_b = regs[in_rb];
  end

  // A register returning this cycle no longer blocks issue.
  always_comb begin
    blk_a = (in_ra != '0) && busy[in_ra]
          && !(wb_en && (wb_addr == in_ra));
    blk_b = (in_rb != '0) && busy[in_rb]
          && !(wb_en && (wb_addr == in_rb));
    blk_d = (in_rd != '0) && busy[in_rd]
          && !(wb_en && (wb_addr == in_rd));
  end

  assign hazard   = in_valid && (blk_a || blk_b || blk_d);
  assign in_ready = !hazard && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Set is applied after clear so a same-cycle reissue stays busy.
  always_comb begin
    busy_n = busy;
    if (wb_hit)
      busy_n[wb_addr] = 1'b0;
    if (accept && (in_rd != '0))
      busy_n[in_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      ctl_q <= '0;
    end else if (accept) begin
      vld_q    <= 1'b1;
      a_q      <= src_a;
      b_q      <= src_b;
      ctl_q.op <= in_op;
      ctl_q.rd <= in_rd;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = ctl_q.op;
  assign out_rd    = ctl_q.rd;

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch/issue stage directly upstream of the 5-bit-opcode, 32-bit ALU.
- Holds the 32x32 architectural register file and accepts one instruction per cycle (op, ra, rb, rd).
- Reads and forwards operands, registers them into alu_a/alu_b/alu_op for the ALU, and accepts ALU results back on a write-back port.
- A per-register busy scoreboard stalls issue on RAW/WAW hazards.

Parameters:
- NREG, 32, number of registers (address width fixed at 5; r0 hardwired zero)
- DW, 32, data width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  stage accepts instruction this cycle
- in_op  in  5  ALU opcode (0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR)
- in_ra  in  5  source A register
- in_rb  in  5  source B register
- in_rd  in  5  destination register (0 = no write-back expected)
- out_valid  out  1  alu_a/alu_b/alu_op/out_rd valid
- out_ready  in  1  ALU side consumes this cycle
- alu_a  out  DW  operand A, registered
- alu_b  out  DW  operand B, registered
- alu_op  out  5  opcode, registered
- out_rd  out  5  destination carried with operands
- wb_en  in  1  write-back strobe
- wb_addr  in  5  write-back register
- wb_data  in  DW  write-back value
- dbg_addr  in  5  debug read address
- dbg_data  out  DW  combinational read of regfile[dbg_addr]; r0 reads 0

Behaviour:
- Reset (rst_n low, async):
  - all registers = 0, all busy bits = 0
  - out_valid = 0, alu_a = 0, alu_b = 0, alu_op = 0 (NOP), out_rd = 0
  - Reset mid-operation discards the held instruction and all pending busy state.
- Write-back:
  - on clk edge with wb_en=1 and wb_addr≠0: reg[wb_addr] ← wb_data, busy[wb_addr] ← 0
  - wb_addr=0 writes are ignored.
- Operand read, combinational in issue cycle:
  - src = 0 if addr=0
  - else wb_data if wb_en && wb_addr==addr (bypass)
  - else reg[addr]
- Hazard: hazard = in_valid and any of:
  - (ra≠0 && busy[ra] && !(wb_en && wb_addr==ra))
  - same for rb
  - (rd≠0 && busy[rd] && !(wb_en && wb_addr==rd))
- Handshake: in_ready = !hazard && (!out_valid || out_ready). in_ready is combinational; no dependency on in_ready from in_valid for legality.
- Accept (in_valid && in_ready):
  - next edge loads alu_a, alu_b, alu_op, out_rd; out_valid ← 1
  - busy[rd] ← 1 if rd≠0
  - Latency from accept to out_valid: 1 cycle.
- Hold: out_valid && !out_ready → outputs held stable, no accept.
- Drain: out_valid && out_ready && no accept → out_valid ← 0; alu_* keep last values.
- Simultaneous busy set (accept, rd=X) and clear (wb, addr=X) in the same cycle: set wins, busy[X]=1.
- Simultaneous write-back to reg X and dbg_addr=X: dbg_data shows the old value until the edge.
- Throughput: one instruction per cycle when hazard-free and out_ready=1.
- Opcodes ≥7 pass through unchanged (the ALU defines them as NOP).
- Busy bits are cleared only by write-back; a never-returned rd stays busy until reset.

Test Plan:
- Reset: rst_n=0 for 3 cycles → out_valid=0, alu_a=alu_b=0, alu_op=0, dbg_data=0 for every dbg_addr 0..31; in_ready=1.
- Write-back then issue: wb r3←0x0000_0010, r4←0x0000_0005; then issue op=2, ra=3, rb=4, rd=5 → next cycle out_valid=1, alu_a=0x10, alu_b=0x5, alu_op=2, out_rd=5.
- RAW stall then forward: issue rd=5, then immediately issue ra=5 → in_ready=0 until the cycle wb_en=1, wb_addr=5, wb_data=0xB. In that cycle in_ready=1; next cycle alu_a=0xB.
- r0 rules: wb r0←0xFFFF_FFFF, then issue ra=0, rb=0, rd=0 → alu_a=alu_b=0, no busy set; a follow-up issue with ra=0 never stalls.
- Backpressure: out_ready=0 with in_valid=1 for 4 cycles → in_ready=0 and outputs frozen; out_ready=1 → next instruction accepted the same cycle, new operands appear the following cycle.
- Async reset mid-stall: r7 busy, out_valid=1; pulse rst_n low between edges → out_valid drops immediately, busy cleared; an issue with ra=7 is accepted on the first cycle after release.
